// File: rtl/dram_wb_arbiter.sv
// Round-robin arbiter sharing the DRAM wrapper's single Wishbone-style port
// between NUM_MASTERS requesters. It grants one whole transaction at a time,
// registers the granted request towards the wrapper and routes ack/read data
// back to the owner. All traffic is held off until calibration is done. A
// missing ack is recovered with a timeout error pulse.
module dram_wb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned WORD_SIZE      = 256,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              initialized_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*WORD_SIZE-1:0]  m_data_i,
  output logic [WORD_SIZE-1:0]              m_data_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [WORD_SIZE-1:0]              s_data_o,
  input  logic [WORD_SIZE-1:0]              s_data_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              busy_o
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic                    s_req_q, s_req_d;
  logic                    s_we_q, s_we_d;
  logic [ADDR_WIDTH-1:0]   s_addr_q, s_addr_d;
  logic [WORD_SIZE-1:0]    s_data_q, s_data_d;
  logic [WORD_SIZE-1:0]    m_data_q, m_data_d;
  logic [NUM_MASTERS-1:0]  m_ack_q, m_ack_d;
  logic [NUM_MASTERS-1:0]  m_err_q, m_err_d;

  logic [NUM_MASTERS-1:0]  req;
  logic                    pick_valid;
  logic [IdxW-1:0]         pick_idx;
  logic [IdxW-1:0]         next_ptr;
  logic                    timeout_hit;
  int unsigned             cand;

  // Round-robin pick: first requesting index at or after the pointer, wrapping.
  always_comb begin
    req        = m_cyc_i & m_stb_i;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = (32'(ptr_q) + k) % NUM_MASTERS;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IdxW'(cand);
      end
    end
  end

  // Pointer moves to the slot just after the finishing owner; timeout detect.
  always_comb begin
    next_ptr    = (owner_q == IdxW'(NUM_MASTERS - 1)) ? '0 : owner_q + IdxW'(1);
    timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

  // Next-state and registered-output logic for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    s_req_d  = s_req_q;
    s_we_d   = s_we_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    m_data_d = m_data_q;
    m_ack_d  = '0;
    m_err_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (initialized_i && pick_valid) begin
          state_d  = StBusy;
          owner_d  = pick_idx;
          grant_d  = NUM_MASTERS'(1) << pick_idx;
          s_req_d  = 1'b1;
          s_we_d   = m_we_i[pick_idx];
          s_addr_d = m_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          s_data_d = m_data_i[pick_idx*WORD_SIZE +: WORD_SIZE];
          cnt_d    = '0;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CntW'(1);
        // Ack takes priority over a coincident timeout.
        if (s_ack_i) begin
          // An owner that already dropped cyc gets no ack; the DRAM side
          // still completes normally.
          m_ack_d[owner_q] = m_cyc_i[owner_q];
          m_data_d         = s_data_i;
          s_req_d          = 1'b0;
          ptr_d            = next_ptr;
          state_d          = StDone;
        end else if (timeout_hit) begin
          m_err_d[owner_q] = 1'b1;
          s_req_d          = 1'b0;
          ptr_d            = next_ptr;
          state_d          = StDone;
        end
      end
      StDone: begin
        // One guard cycle so the owner's stale stb is never re-granted.
        grant_d = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        s_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      s_req_q  <= 1'b0;
      s_we_q   <= 1'b0;
      s_addr_q <= '0;
      s_data_q <= '0;
      m_data_q <= '0;
      m_ack_q  <= '0;
      m_err_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      s_req_q  <= s_req_d;
      s_we_q   <= s_we_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      m_data_q <= m_data_d;
      m_ack_q  <= m_ack_d;
      m_err_q  <= m_err_d;
    end
  end

  // Output drive; cyc and stb are the same registered request.
  always_comb begin
    m_data_o = m_data_q;
    m_ack_o  = m_ack_q;
    m_err_o  = m_err_q;
    s_cyc_o  = s_req_q;
    s_stb_o  = s_req_q;
    s_we_o   = s_we_q;
    s_addr_o = s_addr_q;
    s_data_o = s_data_q;
    grant_o  = grant_q;
    busy_o   = (state_q != StIdle);
  end

endmodule

// File: tb/tb_dram_wb_arbiter.sv
// Directed bench for dram_wb_arbiter: a cycle table for init gating, single
// write and round-robin, then hand sequences for read routing, timeout,
// dropped owner, mid-transaction reset and request latching.
module tb_dram_wb_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned W  = 256;
  localparam int unsigned AW = 32;

  localparam logic [AW-1:0] A0 = 32'h0000_0080;
  localparam logic [AW-1:0] A1 = 32'h0000_0100;
  localparam logic [W-1:0]  D0 = {8{32'h1111_0000}};
  localparam logic [W-1:0]  D1 = {8{32'h2222_0000}};
  localparam logic [W-1:0]  RD = 256'hAABBCCDD_EEFF0011_22334455_66778899_AABBCCDD_EEFF0011_22334455_66778899;

  logic            clk;
  logic            rst_n;
  logic            initialized_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*W-1:0]  m_data_i;
  logic [W-1:0]    m_data_o;
  logic [N-1:0]    m_ack_o, m_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [W-1:0]    s_data_o;
  logic [W-1:0]    s_data_i;
  logic            s_ack_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  int passed = 0;
  int total  = 0;

  dram_wb_arbiter #(
    .NUM_MASTERS   (N),
    .WORD_SIZE     (W),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .initialized_i(initialized_i),
    .m_cyc_i      (m_cyc_i),
    .m_stb_i      (m_stb_i),
    .m_we_i       (m_we_i),
    .m_addr_i     (m_addr_i),
    .m_data_i     (m_data_i),
    .m_data_o     (m_data_o),
    .m_ack_o      (m_ack_o),
    .m_err_o      (m_err_o),
    .s_cyc_o      (s_cyc_o),
    .s_stb_o      (s_stb_o),
    .s_we_o       (s_we_o),
    .s_addr_o     (s_addr_o),
    .s_data_o     (s_data_o),
    .s_data_i     (s_data_i),
    .s_ack_i      (s_ack_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          init;
    logic [N-1:0]  cyc;
    logic [N-1:0]  stb;
    logic [N-1:0]  we;
    logic          ack;
    logic [N-1:0]  e_grant;
    logic          e_stb;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_mack;
    logic [N-1:0]  e_merr;
    logic          e_busy;
  } vec_t;

  vec_t vecs[25];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    s_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int err_seen;
    int stb_low;

    rst_n         = 1'b0;
    initialized_i = 1'b0;
    idle_inputs();
    m_addr_i = {A1, A0};
    m_data_i = {D1, D0};
    s_data_i = '0;

    // rst init cyc    stb    we     ack  grant  stb  we   addr mack   merr   busy
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, A0, 2'b00, 2'b00, 1'b0};
    // Calibration not done: no grant.
    vecs[1]  = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, A0, 2'b00, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, A0, 2'b00, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0, 2'b00, 2'b00, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0, 2'b00, 2'b00, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0, 2'b00, 2'b00, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0, 2'b00, 2'b00, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0, 2'b00, 2'b00, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0, A0, 2'b01, 2'b00, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, A0, 2'b00, 2'b00, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, A0, 2'b00, 2'b00, 1'b0};
    // Round-robin with both masters requesting continuously, ack on 3rd busy cycle.
    vecs[11] = '{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, A0, 2'b00, 2'b00, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0, 2'b00, 2'b00, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0, 2'b00, 2'b00, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0, A0, 2'b01, 2'b00, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, A0, 2'b00, 2'b00, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b10, 1'b1, 1'b0, A1, 2'b00, 2'b00, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b10, 1'b1, 1'b0, A1, 2'b00, 2'b00, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0, A1, 2'b10, 2'b00, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, A0, 2'b00, 2'b00, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0, 2'b00, 2'b00, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, A0, 2'b00, 2'b00, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0, A0, 2'b01, 2'b00, 1'b1};
    vecs[23] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, A0, 2'b00, 2'b00, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 2'b10, 1'b1, 1'b0, A1, 2'b00, 2'b00, 1'b1};

    tick();
    for (int i = 0; i < 25; i++) begin
      rst_n         = !vecs[i].rst;
      initialized_i = vecs[i].init;
      m_cyc_i       = vecs[i].cyc;
      m_stb_i       = vecs[i].stb;
      m_we_i        = vecs[i].we;
      s_ack_i       = vecs[i].ack;
      tick();
      check($sformatf("row%0d grant", i), W'(grant_o), W'(vecs[i].e_grant));
      check($sformatf("row%0d s_stb", i), W'(s_stb_o), W'(vecs[i].e_stb));
      check($sformatf("row%0d s_cyc", i), W'(s_cyc_o), W'(vecs[i].e_stb));
      check($sformatf("row%0d m_ack", i), W'(m_ack_o), W'(vecs[i].e_mack));
      check($sformatf("row%0d m_err", i), W'(m_err_o), W'(vecs[i].e_merr));
      check($sformatf("row%0d busy", i), W'(busy_o), W'(vecs[i].e_busy));
      if (vecs[i].e_stb) begin
        check($sformatf("row%0d s_addr", i), W'(s_addr_o), W'(vecs[i].e_addr));
        check($sformatf("row%0d s_we", i), W'(s_we_o), W'(vecs[i].e_we));
      end
    end

    // Read data routing to master 1.
    do_reset();
    initialized_i = 1'b1;
    m_cyc_i = 2'b10;
    m_stb_i = 2'b10;
    tick();
    check("rd grant", W'(grant_o), W'(2'b10));
    check("rd s_addr", W'(s_addr_o), W'(A1));
    check("rd s_we", W'(s_we_o), W'(1'b0));
    tick();
    s_ack_i  = 1'b1;
    s_data_i = RD;
    tick();
    check("rd m_ack", W'(m_ack_o), W'(2'b10));
    check("rd m_data", m_data_o, RD);
    check("rd grant done", W'(grant_o), W'(2'b10));
    idle_inputs();
    s_data_i = '0;
    tick();
    check("rd grant idle", W'(grant_o), W'(2'b00));
    check("rd ack pulse", W'(m_ack_o), W'(2'b00));

    // Timeout on master 0, then master 1's pending request is served.
    do_reset();
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    tick();
    check("to grant", W'(grant_o), W'(2'b01));
    err_seen = 0;
    stb_low  = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (m_err_o != 2'b00) err_seen++;
      if (!s_stb_o) stb_low++;
    end
    check("to early err", W'(err_seen), W'(0));
    check("to stb held", W'(stb_low), W'(0));
    tick();
    check("to m_err", W'(m_err_o), W'(2'b01));
    check("to m_ack", W'(m_ack_o), W'(2'b00));
    check("to s_stb", W'(s_stb_o), W'(1'b0));
    m_cyc_i = 2'b10;
    m_stb_i = 2'b10;
    tick();
    check("to err pulse", W'(m_err_o), W'(2'b00));
    tick();
    check("to next grant", W'(grant_o), W'(2'b10));
    check("to next addr", W'(s_addr_o), W'(A1));
    s_ack_i = 1'b1;
    tick();
    check("to next ack", W'(m_ack_o), W'(2'b10));
    idle_inputs();
    tick();

    // Owner drops cyc mid-transaction: no ack forwarded.
    do_reset();
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    tick();
    tick();
    idle_inputs();
    tick();
    check("drop busy", W'(busy_o), W'(1'b1));
    s_ack_i = 1'b1;
    tick();
    check("drop m_ack", W'(m_ack_o), W'(2'b00));
    check("drop s_stb", W'(s_stb_o), W'(1'b0));
    s_ack_i = 1'b0;
    tick();
    check("drop idle", W'(busy_o), W'(1'b0));

    // Reset mid-transaction, then a late ack is ignored.
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    m_we_i  = 2'b01;
    tick();
    check("rst pre busy", W'(s_stb_o), W'(1'b1));
    rst_n = 1'b0;
    tick();
    check("rst grant", W'(grant_o), W'(2'b00));
    check("rst s_stb", W'(s_stb_o), W'(1'b0));
    check("rst s_we", W'(s_we_o), W'(1'b0));
    check("rst s_addr", W'(s_addr_o), W'(0));
    check("rst s_data", s_data_o, W'(0));
    check("rst m_data", m_data_o, W'(0));
    check("rst busy", W'(busy_o), W'(1'b0));
    rst_n = 1'b1;
    idle_inputs();
    s_ack_i = 1'b1;
    tick();
    check("rst late ack", W'(m_ack_o), W'(2'b00));
    check("rst late busy", W'(busy_o), W'(1'b0));
    s_ack_i = 1'b0;

    // Request stays latched while master inputs change and calibration drops.
    do_reset();
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    m_we_i  = 2'b01;
    tick();
    check("latch s_data", s_data_o, D0);
    m_addr_i      = {A1, 32'h0000_03C0};
    m_data_i      = {D1, ~D0};
    m_we_i        = 2'b00;
    initialized_i = 1'b0;
    tick();
    tick();
    check("latch s_addr held", W'(s_addr_o), W'(A0));
    check("latch s_data held", s_data_o, D0);
    check("latch s_we held", W'(s_we_o), W'(1'b1));
    s_ack_i = 1'b1;
    tick();
    check("latch m_ack", W'(m_ack_o), W'(2'b01));
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dram_wb_arbiter.md
Name: dram_wb_arbiter

Overview:
Round-robin arbiter that shares the single Wishbone-style port of the DRAM wrapper (cyc/stb/we/addr/data/ack, 256-bit words) between NUM_MASTERS requesters, e.g. a memory-test engine and a DMA/host bridge. It grants one whole transaction at a time. It registers the granted request towards the wrapper and routes the ack and read data back to the owner. It also holds off all traffic until DRAM calibration completes, and recovers from a missing ack with a timeout error.

Parameters:
NUM_MASTERS, 2, number of requesters (2..8)
WORD_SIZE, 256, data width in bits
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 4096, maximum clk cycles to wait for s_ack_i before aborting (>=2)

Ports:
clk  in  1  clock, same domain as the wrapper sys_clk
rst_n  in  1  reset; synchronous, active-low
initialized_i  in  1  DRAM calibration done, from wrapper
m_cyc_i  in  NUM_MASTERS  per-master cycle
m_stb_i  in  NUM_MASTERS  per-master strobe
m_we_i  in  NUM_MASTERS  per-master write enable
m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_data_i  in  NUM_MASTERS*WORD_SIZE  packed write data, same packing
m_data_o  out  WORD_SIZE  read data, shared; valid only with m_ack_o
m_ack_o  out  NUM_MASTERS  one-hot completion pulse
m_err_o  out  NUM_MASTERS  one-hot timeout pulse
s_cyc_o, s_stb_o, s_we_o  out  1 each  to wrapper
s_addr_o  out  ADDR_WIDTH  to wrapper
s_data_o  out  WORD_SIZE  to wrapper
s_data_i  in  WORD_SIZE  read data from wrapper
s_ack_i  in  1  ack from wrapper
grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle
busy_o  out  1  high in BUSY and DONE

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0: m_data_o, s_addr_o and s_data_o are zero. Priority pointer = 0. Timeout counter = 0. Applying reset mid-transaction abandons the transaction; any later s_ack_i is ignored.
- A request from master i is m_cyc_i[i] & m_stb_i[i].
- IDLE: no arbitration while initialized_i=0.
  - Otherwise, among the requesting masters, pick the first index at or after the pointer, wrapping modulo NUM_MASTERS.
  - At the next edge: grant_o = onehot(g). Latch s_we_o, s_addr_o and s_data_o from master g. Set s_cyc_o = s_stb_o = 1. Clear the counter. Go to BUSY.
  - Latency from request to s_stb_o is 1 cycle.
- BUSY: s_* outputs are held stable. Changes on master inputs are ignored, because the request is latched. The counter increments each cycle.
  - s_ack_i=1: at the next edge, m_ack_o[g]=1 for exactly 1 cycle, m_data_o = s_data_i (captured for writes too), s_cyc_o = s_stb_o = 0, pointer = (g+1) mod NUM_MASTERS, go to DONE.
  - If m_cyc_i[g] has dropped by the ack cycle, m_ack_o stays 0. The wrapper transaction still completes normally; there is no abort towards DRAM.
  - Timeout: the counter reaches TIMEOUT_CYCLES-1 with no ack. At the next edge: m_err_o[g]=1 for 1 cycle, m_ack_o=0, s_cyc_o = s_stb_o = 0, pointer advances, go to DONE.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE: lasts one cycle. grant_o is still onehot(g). The owner drops its stb on the edge where it sees m_ack_o. DONE then returns to IDLE with grant_o = 0. A new grant is therefore issued no earlier than 2 cycles after m_ack_o, so a stale stb can never be re-granted.
- s_ack_i is ignored in IDLE and DONE.
- initialized_i falling during BUSY does not abort the transaction; it only blocks new grants.
- Fairness: with all masters requesting continuously, grants rotate 0,1,…,N-1,0. Each master waits at most NUM_MASTERS-1 transactions.

Test Plan:
- Single master, NUM_MASTERS=2: initialized_i=0 while m0 requests a write to addr 0x80 -> no s_stb_o. Raise initialized_i -> s_stb_o=1, s_addr_o=0x80, s_we_o=1 one cycle later. s_ack_i after 5 cycles -> m_ack_o=2'b01 one cycle later for exactly 1 cycle.
- Read data routing: m1 reads addr 0x100 and the wrapper returns 256'hAABBCCDD…8899 with ack -> m_ack_o=2'b10, m_data_o equals that value, grant_o=2'b10 through DONE, then 0.
- Round-robin: both masters request continuously with an ack after 3 cycles each -> grant order 0,1,0,1 and no master granted twice in a row.
- Timeout with TIMEOUT_CYCLES=16: m0 requests and s_ack_i is never asserted -> m_err_o=2'b01 pulse 16 cycles after s_stb_o rises, s_stb_o=0, then m1's pending request is granted.
- Owner drops cyc mid-BUSY, then s_ack_i -> no m_ack_o, return to IDLE. Assert rst_n=0 mid-BUSY, then s_ack_i after reset -> all outputs 0 and no ack forwarded.
- Stable latching: m0 changes m_addr_i and m_data_i during BUSY -> s_addr_o and s_data_o unchanged until the ack.
